// File: rtl/uart_tx_fifo_if.sv
// Bundle of the enqueue port and the serial/status outputs of uart_tx_fifo.
//
// Handshake: wr_en acts as "valid" and !fifo_full acts as "ready". A word is
// transferred on a rising edge where wr_en=1 and fifo_full=0. A write offered
// while fifo_full=1 is not retried: it is dropped and the sticky overflow flag
// records the loss. There is no back-pressure beyond fifo_full.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              tx;
  logic              tx_busy;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;
  logic [2:0]        state_out;

  modport master (
    output data_in, wr_en,
    input  tx, tx_busy, fifo_full, fifo_empty, overflow, state_out
  );

  modport slave (
    input  data_in, wr_en,
    output tx, tx_busy, fifo_full, fifo_empty, overflow, state_out
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small power-of-2 FIFO. Frames are
// start / DATA_W data bits LSB first / optional parity / 1 or 2 stop bits,
// each bit CLKS_PER_BIT cycles long. Back-to-back words are sent with no idle
// gap between the last stop bit and the next start bit.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk_tx,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic          ODD_PAR    = (PARITY_MODE == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              overflow_r;
  logic [DATA_W-1:0] head;

  logic [2:0]        state;
  logic [CW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              parity_bit;
  logic              bit_done;
  logic              tx_line;

  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);
  assign push     = bus.wr_en && !full;
  assign head     = mem[rd_ptr];
  assign bit_done = (baud_cnt == BAUD_LAST);

  // Pop the head word when idle, or at the very end of the last stop bit so
  // the next start bit follows without a gap.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE) begin
        pop = 1'b1;
      end else if (state == S_STOP && bit_done && bit_cnt == STOP_LAST) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_tx) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && full) overflow_r <= 1'b1;
    end
  end

  // Frame sequencer: baud counter reloads at every bit boundary, bit counter
  // tracks data bits and then stop bits.
  always_ff @(posedge clk_tx or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shreg      <= head;
            parity_bit <= (^head) ^ ODD_PAR;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shreg      <= head;
                parity_bit <= (^head) ^ ODD_PAR;
                state      <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Line level follows the state; anything unrecognised idles high.
  always_comb begin
    tx_line = 1'b1;
    case (state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = shreg[0];
      S_PARITY: tx_line = parity_bit;
      default:  tx_line = 1'b1;
    endcase
  end

  assign bus.tx         = tx_line;
  assign bus.tx_busy    = (state != S_IDLE) || !empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.overflow   = overflow_r;
  assign bus.state_out  = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances with different frame formats,
// a frame-level reference model, a per-cycle compare process and directed
// vectors with hand-computed literal expectations.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  // instance 0: 8E1, instance 1: 8N2, instance 2: 7O1
  localparam int P_DW[3]   = '{8, 8, 7};
  localparam int P_PAR[3]  = '{1, 0, 2};
  localparam int P_STOP[3] = '{1, 2, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic [2:0] wr_v = 3'b000;
  logic [8:0] din_v [3];

  logic       tx_v   [3];
  logic       busy_v [3];
  logic       full_v [3];
  logic       empty_v[3];
  logic       ovf_v  [3];
  logic [2:0] st_v   [3];

  uart_tx_fifo_if #(.DATA_W(8)) if_a ();
  uart_tx_fifo_if #(.DATA_W(8)) if_b ();
  uart_tx_fifo_if #(.DATA_W(7)) if_c ();

  assign if_a.wr_en = wr_v[0];
  assign if_b.wr_en = wr_v[1];
  assign if_c.wr_en = wr_v[2];
  assign if_a.data_in = din_v[0][7:0];
  assign if_b.data_in = din_v[1][7:0];
  assign if_c.data_in = din_v[2][6:0];

  assign tx_v[0] = if_a.tx;          assign tx_v[1] = if_b.tx;          assign tx_v[2] = if_c.tx;
  assign busy_v[0] = if_a.tx_busy;   assign busy_v[1] = if_b.tx_busy;   assign busy_v[2] = if_c.tx_busy;
  assign full_v[0] = if_a.fifo_full; assign full_v[1] = if_b.fifo_full; assign full_v[2] = if_c.fifo_full;
  assign empty_v[0] = if_a.fifo_empty;
  assign empty_v[1] = if_b.fifo_empty;
  assign empty_v[2] = if_c.fifo_empty;
  assign ovf_v[0] = if_a.overflow;   assign ovf_v[1] = if_b.overflow;   assign ovf_v[2] = if_c.overflow;
  assign st_v[0] = if_a.state_out;   assign st_v[1] = if_b.state_out;   assign st_v[2] = if_c.state_out;

  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_a (.clk_tx(clk), .rst(rst), .bus(if_a));
  uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
    dut_b (.clk_tx(clk), .rst(rst), .bus(if_b));
  uart_tx_fifo #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_c (.clk_tx(clk), .rst(rst), .bus(if_c));

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Words waiting to be sent, plus the frame on the line described only by
  // which word it is and how many cycles have elapsed since its start bit.
  int mq[3][$];
  bit m_act [3];
  int m_pos [3];
  int m_word[3];
  bit m_ovf [3];

  function automatic int frame_len(input int d);
    return (1 + P_DW[d] + ((P_PAR[d] != 0) ? 1 : 0) + P_STOP[d]) * CPB;
  endfunction

  // Line level for bit slot idx of a frame carrying word w.
  function automatic logic frame_bit(input int d, input int w, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < P_DW[d]; i++) ones += w[i];
    if (idx == 0) return 1'b0;
    if (idx <= P_DW[d]) return w[idx-1];
    if (P_PAR[d] != 0 && idx == P_DW[d] + 1)
      return (P_PAR[d] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int d);
    if (!m_act[d]) return 1'b1;
    return frame_bit(d, m_word[d], m_pos[d] / CPB);
  endfunction

  function automatic logic [2:0] exp_state(input int d);
    int idx;
    if (!m_act[d]) return 3'd0;
    idx = m_pos[d] / CPB;
    if (idx == 0) return 3'd1;
    if (idx <= P_DW[d]) return 3'd2;
    if (P_PAR[d] != 0 && idx == P_DW[d] + 1) return 3'd3;
    return 3'd4;
  endfunction

  // Advance the model one clock using the inputs seen at that edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          mq[d].delete();
          m_act[d] = 1'b0;
          m_pos[d] = 0;
          m_ovf[d] = 1'b0;
        end else begin
          int  n_before;
          bit  take;
          n_before = mq[d].size();
          take = 1'b0;
          if (m_act[d]) begin
            if (m_pos[d] == frame_len(d) - 1) begin
              if (n_before > 0) take = 1'b1;
              else m_act[d] = 1'b0;
            end else begin
              m_pos[d]++;
            end
          end else if (n_before > 0) begin
            take = 1'b1;
          end
          if (take) begin
            m_word[d] = mq[d].pop_front();
            m_act[d]  = 1'b1;
            m_pos[d]  = 0;
          end
          if (wr_v[d]) begin
            if (n_before == DEPTH) m_ovf[d] = 1'b1;
            else mq[d].push_back(int'(din_v[d]) & ((1 << P_DW[d]) - 1));
          end
        end
      end
    end
  end

  // Every falling edge, all outputs of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("tx[%0d]", d), 32'(tx_v[d]), 32'(exp_tx(d)));
        chk($sformatf("state_out[%0d]", d), 32'(st_v[d]), 32'(exp_state(d)));
        chk($sformatf("tx_busy[%0d]", d), 32'(busy_v[d]), 32'(m_act[d] || mq[d].size() > 0));
        chk($sformatf("fifo_full[%0d]", d), 32'(full_v[d]), 32'(mq[d].size() == DEPTH));
        chk($sformatf("fifo_empty[%0d]", d), 32'(empty_v[d]), 32'(mq[d].size() == 0));
        chk($sformatf("overflow[%0d]", d), 32'(ovf_v[d]), 32'(m_ovf[d]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one word at the next falling edge for a single cycle; returns at
  // the falling edge after the accepting rising edge.
  task automatic write_one(input int d, input logic [8:0] val);
    @(negedge clk);
    din_v[d] = val;
    wr_v[d]  = 1'b1;
    @(negedge clk);
    wr_v[d]  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int seq_a5[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    for (int d = 0; d < 3; d++) din_v[d] = '0;
    idle_cycles(3);
    chk("reset_tx", 32'(tx_v[0]), 32'd1);
    chk("reset_state", 32'(st_v[0]), 32'd0);
    chk("reset_empty", 32'(empty_v[0]), 32'd1);
    rst = 1'b0;

    // 8E1 frame of 0xA5: start bit appears one edge after acceptance.
    write_one(0, 9'h0A5);
    @(negedge clk);
    for (int b = 0; b < 11; b++) begin
      chk($sformatf("a5_bit%0d", b), 32'(tx_v[0]), 32'(seq_a5[b]));
      if (b == 10) chk("a5_busy_in_stop", 32'(busy_v[0]), 32'd1);
      idle_cycles(CPB);
    end
    chk("a5_busy_after_44", 32'(busy_v[0]), 32'd0);

    // 7O1 frame of 0x7F: seven ones, so odd parity bit is 0; frame is 40 cycles.
    write_one(2, 9'h07F);
    @(negedge clk);
    idle_cycles(8 * CPB);
    chk("odd_parity_bit", 32'(tx_v[2]), 32'd0);
    chk("odd_parity_state", 32'(st_v[2]), 32'd3);
    idle_cycles(7);
    chk("c_busy_at_39", 32'(busy_v[2]), 32'd1);
    @(negedge clk);
    chk("c_busy_at_40", 32'(busy_v[2]), 32'd0);

    // 8N2 back-to-back 0x01, 0x80: 8 stop cycles then start bit with no gap.
    @(negedge clk);
    din_v[1] = 9'h001;
    wr_v[1]  = 1'b1;
    @(negedge clk);
    din_v[1] = 9'h080;
    @(negedge clk);
    wr_v[1]  = 1'b0;
    idle_cycles(36);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_stop%0d", k), 32'(tx_v[1]), 32'd1);
      @(negedge clk);
    end
    chk("b2b_second_start", 32'(tx_v[1]), 32'd0);
    chk("b2b_second_state", 32'(st_v[1]), 32'd1);
    idle_cycles(50);

    // Six consecutive writes into a depth-4 FIFO: one popped, four queued,
    // the sixth dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) chk("ovf_full_seen", 32'(full_v[0]), 32'd1);
      if (i == 5) chk("ovf_not_yet", 32'(ovf_v[0]), 32'd0);
      din_v[0] = 9'(9'h011 + i);
      wr_v[0]  = 1'b1;
    end
    @(negedge clk);
    wr_v[0] = 1'b0;
    chk("ovf_set", 32'(ovf_v[0]), 32'd1);
    chk("ovf_still_full", 32'(full_v[0]), 32'd1);
    idle_cycles(240);
    chk("ovf_sticky", 32'(ovf_v[0]), 32'd1);

    // Write on the same edge that the idle FSM pops the only entry.
    @(negedge clk);
    din_v[0] = 9'h03A;
    wr_v[0]  = 1'b1;
    @(negedge clk);
    din_v[0] = 9'h05C;
    @(negedge clk);
    wr_v[0] = 1'b0;
    chk("simul_not_empty", 32'(empty_v[0]), 32'd0);
    chk("simul_not_full", 32'(full_v[0]), 32'd0);
    chk("simul_start", 32'(st_v[0]), 32'd1);
    idle_cycles(100);

    // Reset during data bit 3, then a clean frame of 0x55.
    write_one(0, 9'h03C);
    @(negedge clk);
    idle_cycles(4 * CPB + 1);
    chk("pre_rst_in_data", 32'(st_v[0]), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx_v[0]), 32'd1);
    chk("rst_state", 32'(st_v[0]), 32'd0);
    chk("rst_empty", 32'(empty_v[0]), 32'd1);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_ovf", 32'(ovf_v[0]), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    din_v[0] = 9'h055;
    wr_v[0]  = 1'b1;
    @(negedge clk);
    wr_v[0] = 1'b0;
    chk("post_rst_accept", 32'(empty_v[0]), 32'd0);
    @(negedge clk);
    chk("post_rst_start", 32'(tx_v[0]), 32'd0);
    idle_cycles(4 * CPB);
    chk("post_rst_bit3", 32'(tx_v[0]), 32'd0);
    idle_cycles(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set the clk_tx cycles per serial bit; legal range 2..65535.
REQ-003 Parameter PARITY_MODE, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, SHALL set the stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, SHALL set the number of transmit buffer entries; power of 2, 2..16.
REQ-006 clk_tx  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-008 data_in  in  DATA_W  SHALL be the word to enqueue.
REQ-009 wr_en  in  1  SHALL be the active-high enqueue strobe, sampled each rising edge.
REQ-010 tx  out  1  SHALL be the serial line: idle high, LSB first.
REQ-011 tx_busy  out  1  SHALL be high while a frame is in flight or the FIFO is non-empty.
REQ-012 fifo_full  out  1  SHALL be high when the FIFO holds FIFO_DEPTH entries.
REQ-013 fifo_empty  out  1  SHALL be high when the FIFO holds 0 entries.
REQ-014 overflow  out  1  SHALL be the sticky flag for a dropped write.
REQ-015 state_out  out  3  SHALL be the debug FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

Function
REQ-016 The write SHALL be accepted iff wr_en=1 and fifo_full=0 before the edge.
- Count increments one edge later; no same-cycle bypass to tx.
REQ-017 The write SHALL be dropped iff wr_en=1 and fifo_full=1; overflow sets and holds until rst.
- Applies even if a pop occurs on the same edge.
REQ-018 A simultaneous accepted write and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 From IDLE with fifo_empty=0, the FSM SHALL pop the head word into the shift register and enter START on the next edge.
- tx=0 from that edge; write-to-start-bit latency = 2 edges from an empty, idle block.
REQ-021 Each bit state SHALL hold tx for exactly CLKS_PER_BIT cycles.
- Timing set by a baud counter that reloads on every bit boundary.
REQ-022 DATA SHALL shift out DATA_W bits, LSB first.
REQ-023 After DATA, the FSM SHALL enter PARITY if PARITY_MODE≠0, else STOP.
- Even mode: parity bit = XOR of data bits.
- Odd mode: parity bit = its inverse.
REQ-024 STOP SHALL drive tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
REQ-025 At the end of STOP with fifo_empty=0, the FSM SHALL pop and enter START directly, with no idle gap.
REQ-026 At the end of STOP with fifo_empty=1, the FSM SHALL enter IDLE.
REQ-027 Frame length SHALL be (1 + DATA_W + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
REQ-028 Writes during a frame SHALL be queued and SHALL NOT disturb the frame in flight.
REQ-029 Unreachable state encodings SHALL return to IDLE with tx=1 on the next edge.

Reset
REQ-030 rst=1 SHALL immediately force the following, independent of clk_tx:
- tx=1, state IDLE
- FIFO emptied: fifo_empty=1, fifo_full=0
- overflow=0, tx_busy=0
- baud and bit counters = 0
REQ-031 rst asserted mid-frame SHALL abort the frame; tx=1 without completing the stop bit.
REQ-032 After rst deasserts, the block SHALL accept a write on the first rising edge.

Verification
REQ-033 Single even-parity frame:
- Stimulus: DATA_W=8, CLKS_PER_BIT=4, PARITY_MODE=1, STOP_BITS=1; write 0xA5.
- Response: tx = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; tx_busy low 44 cycles after the start bit.
REQ-034 Back-to-back, no parity, 2 stop bits:
- Stimulus: PARITY_MODE=0, STOP_BITS=2; write 0x01 then 0x80 on consecutive cycles.
- Response: second start bit directly follows 8 high cycles of stop; no extra idle cycle.
REQ-035 Overflow with FIFO_DEPTH=4:
- Stimulus: 6 writes on consecutive cycles.
- Response: first 4 entries queued plus 1 popped; fifo_full observed; overflow=1 on the dropped write; transmitted order preserved.
REQ-036 Odd parity:
- Stimulus: PARITY_MODE=2, DATA_W=7; write 0x7F.
- Response: parity bit = 0.
REQ-037 Reset mid-frame:
- Stimulus: rst pulsed during DATA bit 3.
- Response: tx=1, state_out=0, fifo_empty=1 immediately; a subsequent write of 0x55 transmits a correct full frame.
REQ-038 Simultaneous write and pop:
- Stimulus: write on the exact edge where IDLE pops the last entry.
- Response: count unchanged at 1; the new word is sent as the next frame.
